// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; a grant covers one burst of up to MAX_BURST beats.
// Grant one cycle after valid, zero-latency data path, one idle bubble between grants; FIFO full stalls the grantee in place.
module fifo_write_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_LEN  = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ*DATA_LEN-1:0]   i_req_data,
   input  logic [NUM_REQ-1:0]            i_req_last,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic                          i_fifo_full,
   output logic                          o_fifo_write,
   output logic [DATA_LEN-1:0]           o_fifo_data,
   output logic [NUM_REQ-1:0]            o_grant,
   output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
   output logic                          o_busy
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDW-1:0]     grant_id_q, grant_id_d;
   logic [CW-1:0]      count_q, count_d;
   logic [IDW-1:0]     cand, sel;
   logic               found;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_id_q <= IDW'(NUM_REQ - 1);
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         count_q    <= count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      grant_id_d   = grant_id_q;
      count_d      = count_q;
      cand         = '0;
      sel          = '0;
      found        = 1'b0;
      o_req_ready  = '0;
      o_fifo_write = 1'b0;
      o_fifo_data  = '0;
      case (state_q)
         IDLE: begin
            // Search starts just past the last grantee, so it ends up lowest priority.
            for (int i = 1; i <= NUM_REQ; i++) begin
               cand = IDW'((int'(grant_id_q) + i) % NUM_REQ);
               if (!found && i_req_valid[cand]) begin
                  found = 1'b1;
                  sel   = cand;
               end
            end
            if (found) begin
               state_d    = GRANT;
               grant_d    = NUM_REQ'(1) << sel;
               grant_id_d = sel;
               count_d    = '0;
            end
         end
         GRANT: begin
            o_req_ready[grant_id_q] = !i_fifo_full;
            o_fifo_write            = i_req_valid[grant_id_q] && !i_fifo_full;
            o_fifo_data             = i_req_data[int'(grant_id_q)*DATA_LEN +: DATA_LEN];
            if (o_fifo_write) begin
               count_d = count_q + CW'(1);
               if (i_req_last[grant_id_q] || count_q == CW'(MAX_BURST - 1)) begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else if (!i_req_valid[grant_id_q] && !i_fifo_full) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      // A reset cycle must never write, even if the registers still hold a grant.
      if (i_reset) begin
         o_req_ready  = '0;
         o_fifo_write = 1'b0;
         o_fifo_data  = '0;
      end
   end

   assign o_grant    = grant_q;
   assign o_grant_id = grant_id_q;
   assign o_busy     = (state_q == GRANT);
endmodule
